fast_scan_ctrl: RTL and testbench
=================================

// Module: fast_scan_ctrl
// PURPOSE
//  Frame-scan sequencer for the FAST detector's pixel_pos raster counter.
//  - Accepts a start request with frame dimensions.
//  - Loads pixel_pos and steps it one pixel per accepted downstream transfer.
//  - Tags each position as interior (outside the FAST border) or not.
//  - Reports busy/done and rejects illegal configurations.
// PARAMETERS
//  X_MAX   256  max frame width; XW = $clog2(X_MAX+1)
//  Y_MAX   256  max frame height; YW = $clog2(Y_MAX+1)
//  BORDER  3    FAST circle radius; pixels within BORDER of any edge are non-interior
// PORTS
//  clk          in   1   single clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   job request, sampled in IDLE only
//  cfg_w        in   XW  frame width, legal 1..X_MAX
//  cfg_h        in   YW  frame height, legal 1..Y_MAX
//  busy         out  1   job in progress (LOAD or SCAN)
//  done         out  1   1-cycle pulse after the last pixel transfer
//  cfg_err      out  1   1-cycle pulse when start is rejected
//  pp_new_trans out  1   to pixel_pos: reload and zero position
//  pp_update_pos out 1   to pixel_pos: advance one raster step
//  pp_max_x     out  XW  to pixel_pos: latched width
//  pp_max_y     out  YW  to pixel_pos: latched height
//  pp_end_pos   in   1   from pixel_pos: high while at last pixel (w-1,h-1)
//  pp_curr_x    in   XW  from pixel_pos: current x, 0..w-1
//  pp_curr_y    in   YW  from pixel_pos: current y, 0..h-1
//  ds_ready     in   1   downstream window buffer can accept a position
//  px_valid     out  1   position on px_x/px_y is offered
//  px_x         out  XW  = pp_curr_x
//  px_y         out  YW  = pp_curr_y
//  px_interior  out  1   BORDER<=x<w-BORDER and BORDER<=y<h-BORDER
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; w_lat/h_lat=0. Reset mid-job aborts at once.
//    No done pulse. pixel_pos is reloaded by the next LOAD.
//  - FSM states: IDLE -> LOAD -> SCAN -> DONE -> IDLE.
//  - IDLE, start=1:
//    - Dims legal: latch cfg_w/cfg_h into w_lat/h_lat, go to LOAD.
//    - cfg_w=0, cfg_h=0, cfg_w>X_MAX or cfg_h>Y_MAX: cfg_err=1 next cycle, stay IDLE.
//  - LOAD (1 cycle): pp_new_trans=1, busy=1, px_valid=0, then go to SCAN.
//  - SCAN: busy=1, px_valid=1 (combinational on state).
//    - pp_update_pos = px_valid & ds_ready; a transfer occurs on that cycle.
//    - Transfer with pp_end_pos=1: do not step, go to DONE.
//  - DONE (1 cycle): done=1, busy=0, px_valid=0, then go to IDLE.
//  - pp_max_x/pp_max_y = w_lat/h_lat, stable from LOAD until the next LOAD.
//  - start while busy or in DONE: ignored, no error.
//  - ds_ready low: px_x/px_y/px_interior held stable, no step (back-pressure).
//  - px_interior computed in XW+1 bits; no underflow when w<=2*BORDER (then always 0).
//  - 1x1 frame: LOAD, one SCAN transfer with pp_end_pos=1, DONE.
//    Minimum job = 3 cycles from start sample.
//  - Throughput: w*h SCAN cycles with ds_ready held high.
//    start-to-done = w*h+2 cycles.
// CONFIGURATION
//  FSC_STALL_CNT_EN defined:
//  - adds port stall_cnt out 32: counts SCAN cycles with ds_ready=0.
//  - cleared in LOAD, saturates at 2^32-1, holds after DONE.
//  - reset value 0.
//  Undefined: no stall_cnt port, no counter logic.
// TESTING
//  - Reset: rst=1 for 2 cycles -> busy, done, cfg_err, pp_* and px_valid all 0.
//  - 5x5, ds_ready=1:
//    - 1 pp_new_trans pulse.
//    - 25 px_valid transfers in raster order (0,0)..(4,4).
//    - done exactly 27 cycles after start.
//    - interior only at (3..1) -> none, since 5<=2*3.
//  - 8x8, BORDER=3, ds_ready toggling 1/0:
//    - 64 transfers, ordered and unrepeated.
//    - px_interior=1 only at (3,3),(4,3),(3,4),(4,4).
//    - with FSC_STALL_CNT_EN, stall_cnt equals the number of ds_ready=0 SCAN cycles.
//  - Illegal configs:
//    - start with cfg_w=0, cfg_h=4 -> cfg_err pulse, stays IDLE, busy=0.
//    - start with cfg_w=X_MAX+1 -> same.
//  - start pulsed mid-SCAN of a 240x240 frame -> ignored; single done after 57600 transfers.
//  - rst asserted at pixel 10 of a 16x16 scan -> IDLE next cycle.
//    A new start reloads and scans 256 pixels from (0,0).

Source files
------------

// File: rtl/fast_scan_ctrl.sv
// Frame-scan sequencer driving the pixel_pos raster counter for the FAST detector.
// Optional macro FSC_STALL_CNT_EN adds a saturating back-pressure counter on port stall_cnt.
module fast_scan_ctrl #(
  parameter int X_MAX  = 256,
  parameter int Y_MAX  = 256,
  parameter int BORDER = 3,
  parameter int XW     = $clog2(X_MAX + 1),
  parameter int YW     = $clog2(Y_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] cfg_w,
  input  logic [YW-1:0] cfg_h,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic          pp_new_trans,
  output logic          pp_update_pos,
  output logic [XW-1:0] pp_max_x,
  output logic [YW-1:0] pp_max_y,
  input  logic          pp_end_pos,
  input  logic [XW-1:0] pp_curr_x,
  input  logic [YW-1:0] pp_curr_y,
  input  logic          ds_ready,
  output logic          px_valid,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic          px_interior
`ifdef FSC_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [XW-1:0] X_MAX_V    = XW'(X_MAX);
  localparam logic [YW-1:0] Y_MAX_V    = YW'(Y_MAX);
  localparam logic [XW:0]   BORDER_X_V = (XW + 1)'(BORDER);
  localparam logic [YW:0]   BORDER_Y_V = (YW + 1)'(BORDER);

  state_t        state_r;
  logic [XW-1:0] w_lat_r;
  logic [YW-1:0] h_lat_r;
  logic          legal_s;
  logic          interior_s;

  // Dimension legality and border classification; one extra bit keeps x+BORDER from wrapping.
  always_comb begin
    legal_s    = 1'b0;
    interior_s = 1'b0;
    if ((cfg_w != {XW{1'b0}}) && (cfg_w <= X_MAX_V) &&
        (cfg_h != {YW{1'b0}}) && (cfg_h <= Y_MAX_V)) begin
      legal_s = 1'b1;
    end else begin
      legal_s = 1'b0;
    end
    if (({1'b0, pp_curr_x} >= BORDER_X_V) &&
        (({1'b0, pp_curr_x} + BORDER_X_V) < {1'b0, w_lat_r}) &&
        ({1'b0, pp_curr_y} >= BORDER_Y_V) &&
        (({1'b0, pp_curr_y} + BORDER_Y_V) < {1'b0, h_lat_r})) begin
      interior_s = 1'b1;
    end else begin
      interior_s = 1'b0;
    end
  end

  // Job sequencer with registered status and pixel_pos control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      w_lat_r      <= {XW{1'b0}};
      h_lat_r      <= {YW{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      pp_new_trans <= 1'b0;
      px_valid     <= 1'b0;
    end else begin
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      pp_new_trans <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && legal_s) begin
            w_lat_r      <= cfg_w;
            h_lat_r      <= cfg_h;
            busy         <= 1'b1;
            pp_new_trans <= 1'b1;
            state_r      <= ST_LOAD;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        ST_LOAD: begin
          px_valid <= 1'b1;
          state_r  <= ST_SCAN;
        end
        ST_SCAN: begin
          if (ds_ready && pp_end_pos) begin
            px_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          px_valid <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign pp_update_pos = px_valid & ds_ready;
  assign pp_max_x      = w_lat_r;
  assign pp_max_y      = h_lat_r;
  assign px_x          = pp_curr_x;
  assign px_y          = pp_curr_y;
  assign px_interior   = px_valid & interior_s;

`ifdef FSC_STALL_CNT_EN
  // Count back-pressured SCAN cycles; cleared at job load, saturating, held after the job.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (state_r == ST_LOAD) begin
      stall_cnt <= 32'd0;
    end else if ((state_r == ST_SCAN) && !ds_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fast_scan_ctrl.sv
// Self-checking bench for fast_scan_ctrl: a behavioural pixel_pos neighbour plus a raster
// reference model (index -> x,y, border rule, job latency) checked under random back-pressure.
module tb_fast_scan_ctrl;

  localparam int XW = 9;
  localparam int YW = 9;
  localparam int BRD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] cfg_w = '0;
  logic [YW-1:0] cfg_h = '0;
  logic          busy, done, cfg_err, pp_new_trans, pp_update_pos;
  logic [XW-1:0] pp_max_x;
  logic [YW-1:0] pp_max_y;
  logic          pp_end_pos;
  logic [XW-1:0] pp_x = '0;
  logic [YW-1:0] pp_y = '0;
  logic          ds_ready = 1'b0;
  logic          px_valid, px_interior;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
`ifdef FSC_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fast_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .pp_new_trans(pp_new_trans), .pp_update_pos(pp_update_pos),
    .pp_max_x(pp_max_x), .pp_max_y(pp_max_y), .pp_end_pos(pp_end_pos),
    .pp_curr_x(pp_x), .pp_curr_y(pp_y), .ds_ready(ds_ready),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_interior(px_interior)
`ifdef FSC_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Neighbouring pixel_pos raster counter: reload on new_trans, step on update, stop at the end.
  always @(posedge clk) begin
    if (pp_new_trans) begin
      pp_x <= '0;
      pp_y <= '0;
    end else if (pp_update_pos && !pp_end_pos) begin
      if (pp_x == pp_max_x - 9'd1) begin
        pp_x <= '0;
        pp_y <= pp_y + 9'd1;
      end else begin
        pp_x <= pp_x + 9'd1;
      end
    end
  end
  assign pp_end_pos = (pp_x == pp_max_x - 9'd1) && (pp_y == pp_max_y - 9'd1);

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 random ready. abort_at >= 0 resets at that pixel.
  task automatic run_job(input int w, input int h, input int mode, input int mid_start,
                         input int abort_at);
    int k, idx, stalls, n_new, done_at, budget, busy_bad, err_seen;
    int ex, ey, ein;
    bit prev_stall;
    logic [XW-1:0] prev_x;
    logic [YW-1:0] prev_y;
    logic prev_in;
    k = 0; idx = 0; stalls = 0; n_new = 0; done_at = 0; busy_bad = 0; err_seen = 0;
    prev_stall = 1'b0; prev_x = '0; prev_y = '0; prev_in = 1'b0;
    budget = 8 * w * h + 50;
    @(negedge clk);
    cfg_w = XW'(w);
    cfg_h = YW'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 1;
    while (done_at == 0 && k < budget) begin
      case (mode)
        0: ds_ready = 1'b1;
        1: ds_ready = ((k % 2) == 1);
        default: ds_ready = 1'($urandom_range(0, 1));
      endcase
      if (mid_start != 0 && k == mid_start) begin
        cfg_w = XW'($urandom_range(1, 50));
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (pp_new_trans) n_new++;
      if (cfg_err) err_seen++;
      if (done) begin
        done_at = k;
        check_val("done_busy", busy, 0);
        check_val("done_valid", px_valid, 0);
      end else begin
        if (!busy) busy_bad++;
        if (abort_at >= 0 && idx == abort_at) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst = 1'b0;
          start = 1'b0;
          check_val("abort_busy", busy, 0);
          check_val("abort_valid", px_valid, 0);
          check_val("abort_done", done, 0);
          check_val("abort_busy_during", busy_bad, 0);
          return;
        end
        if (px_valid) begin
          if (prev_stall) begin
            check_val("hold_x", px_x, prev_x);
            check_val("hold_y", px_y, prev_y);
            check_val("hold_in", px_interior, prev_in);
          end
          if (ds_ready) begin
            ex = idx % w;
            ey = idx / w;
            ein = (ex >= BRD && ex < w - BRD && ey >= BRD && ey < h - BRD) ? 1 : 0;
            check_val("px_x", px_x, ex);
            check_val("px_y", px_y, ey);
            check_val("px_interior", px_interior, ein);
            idx++;
          end else begin
            stalls++;
          end
          prev_stall = !ds_ready;
          prev_x = px_x;
          prev_y = px_y;
          prev_in = px_interior;
        end
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    if (done_at == 0) begin
      check_val("timeout", 0, 1);
    end else begin
      check_val("latency", done_at, w * h + 2 + stalls);
      check_val("transfers", idx, w * h);
      check_val("new_trans", n_new, 1);
      check_val("busy_during", busy_bad, 0);
      check_val("no_cfg_err", err_seen, 0);
      check_val("max_x", pp_max_x, w);
      check_val("max_y", pp_max_y, h);
      @(negedge clk);
      check_val("done_single", done, 0);
      check_val("idle_busy", busy, 0);
`ifdef FSC_STALL_CNT_EN
      check_val("stall_cnt", stall_cnt, stalls);
`endif
    end
  endtask

  task automatic bad_start(input int w, input int h);
    @(negedge clk);
    cfg_w = XW'(w);
    cfg_h = YW'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("cfg_err_pulse", cfg_err, 1);
    check_val("cfg_err_busy", busy, 0);
    @(posedge clk);
    #1;
    check_val("cfg_err_clear", cfg_err, 0);
    check_val("cfg_err_idle", busy, 0);
    check_val("cfg_err_nodone", done, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_cfg_err", cfg_err, 0);
    check_val("rst_new_trans", pp_new_trans, 0);
    check_val("rst_update", pp_update_pos, 0);
    check_val("rst_max_x", pp_max_x, 0);
    check_val("rst_max_y", pp_max_y, 0);
    check_val("rst_valid", px_valid, 0);
    rst = 1'b0;

    run_job(5, 5, 0, 0, -1);
    run_job(8, 8, 1, 0, -1);
    bad_start(0, 4);
    bad_start(257, 4);
    bad_start(4, 0);
    bad_start(4, 257);
    run_job(1, 1, 0, 0, -1);
    for (int i = 0; i < 6; i++) begin
      run_job($urandom_range(1, 12), $urandom_range(1, 12), 2, 0, -1);
    end
    run_job(16, 16, 2, 0, 10);
    run_job(16, 16, 2, 0, -1);
    run_job(256, 1, 1, 0, -1);
    run_job(240, 240, 0, 1000, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
